// File: rtl/exc_ctrl.sv
// Exception/interrupt scheduler between the memory stage and cp0_reg: prioritises
// exception sources, drains outstanding bus traffic, then commits a single-cycle redirect.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int_i,
    input  logic        timer_int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        m_valid_i,
    input  logic [31:0] m_pc_i,
    input  logic        m_in_delayslot_i,
    input  logic [7:0]  m_exc_i,
    input  logic [31:0] m_data_addr_i,
    input  logic        ibus_busy_i,
    input  logic        dbus_busy_i,
    output logic [5:0]  hw_int_o,
    output logic [31:0] except_type_o,
    output logic        cp0_en_o,
    output logic [31:0] cur_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        mem_kill_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        newpc_valid_o
);

    localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [7:0]  int_vec;
    logic        int_pend;
    logic        detect;
    logic [31:0] exc_type;
    logic [31:0] exc_badv;

    logic [31:0] type_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic [31:0] badv_q;

    // Multi-flop synchroniser for the asynchronous external interrupt lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int_i};
        end
    end

    assign hw_int_o = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};
    assign int_vec  = {hw_int_o, cp0_cause_i[9:8]};
    assign int_pend = (|(int_vec & cp0_status_i[15:8])) & cp0_status_i[0] & ~cp0_status_i[1];
    assign detect   = (state_q == IDLE) && m_valid_i && (int_pend || (|m_exc_i));

    // Fixed-priority encoder: interrupts first, then exception flags by ascending bit index
    always_comb begin
        exc_type = '0;
        exc_badv = '0;
        if (int_pend) begin
            exc_type = EXC_TYPE_INT;
        end else if (m_exc_i[0]) begin
            exc_type = EXC_TYPE_ADEL;
            exc_badv = m_pc_i;
        end else if (m_exc_i[1]) begin
            exc_type = EXC_TYPE_RI;
        end else if (m_exc_i[2]) begin
            exc_type = EXC_TYPE_OV;
        end else if (m_exc_i[3]) begin
            exc_type = EXC_TYPE_SYS;
        end else if (m_exc_i[4]) begin
            exc_type = EXC_TYPE_BP;
        end else if (m_exc_i[5]) begin
            exc_type = EXC_TYPE_ADEL;
            exc_badv = m_data_addr_i;
        end else if (m_exc_i[6]) begin
            exc_type = EXC_TYPE_ADES;
            exc_badv = m_data_addr_i;
        end else if (m_exc_i[7]) begin
            exc_type = EXC_TYPE_ERET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Exception context is captured only on the detect cycle and held until the commit finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q <= '0;
            pc_q   <= '0;
            ds_q   <= 1'b0;
            badv_q <= '0;
        end else if (detect) begin
            type_q <= exc_type;
            pc_q   <= m_pc_i;
            ds_q   <= m_in_delayslot_i;
            badv_q <= exc_badv;
        end
    end

    assign cur_inst_addr_o   = pc_q;
    assign is_in_delayslot_o = ds_q;
    assign badvaddr_o        = badv_q;

    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b0;
        mem_kill_o    = 1'b0;
        cp0_en_o      = 1'b0;
        flush_o       = 1'b0;
        newpc_valid_o = 1'b0;
        newpc_o       = '0;
        except_type_o = '0;
        case (state_q)
            IDLE: begin
                stall_o    = detect;
                mem_kill_o = detect;
                if (detect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall_o    = 1'b1;
                mem_kill_o = 1'b1;
                if (!ibus_busy_i && !dbus_busy_i) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                cp0_en_o      = 1'b1;
                except_type_o = type_q;
                flush_o       = 1'b1;
                newpc_valid_o = 1'b1;
                newpc_o       = (type_q == EXC_TYPE_ERET) ? cp0_epc_i : EXC_VECTOR;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: exception priority, bus drain timing,
// interrupt synchronisation/masking, ERET redirect and reset during drain.
module tb_exc_ctrl;

    localparam logic [31:0] VEC       = 32'hBFC0_0380;
    localparam logic [31:0] TYPE_INT  = 32'h1;
    localparam logic [31:0] TYPE_ADEL = 32'h4;
    localparam logic [31:0] TYPE_ADES = 32'h5;
    localparam logic [31:0] TYPE_SYS  = 32'h8;
    localparam logic [31:0] TYPE_RI   = 32'hA;
    localparam logic [31:0] TYPE_ERET = 32'hE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  ext_int_i = '0;
    logic        timer_int_i = 1'b0;
    logic [31:0] cp0_status_i = '0;
    logic [31:0] cp0_cause_i = '0;
    logic [31:0] cp0_epc_i = '0;
    logic        m_valid_i = 1'b0;
    logic [31:0] m_pc_i = '0;
    logic        m_in_delayslot_i = 1'b0;
    logic [7:0]  m_exc_i = '0;
    logic [31:0] m_data_addr_i = '0;
    logic        ibus_busy_i = 1'b0;
    logic        dbus_busy_i = 1'b0;
    logic [5:0]  hw_int_o;
    logic [31:0] except_type_o;
    logic        cp0_en_o;
    logic [31:0] cur_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] badvaddr_o;
    logic        mem_kill_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        newpc_valid_o;

    int checkCount = 0;
    int errorCount = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .ext_int_i(ext_int_i), .timer_int_i(timer_int_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .m_valid_i(m_valid_i), .m_pc_i(m_pc_i), .m_in_delayslot_i(m_in_delayslot_i),
        .m_exc_i(m_exc_i), .m_data_addr_i(m_data_addr_i),
        .ibus_busy_i(ibus_busy_i), .dbus_busy_i(dbus_busy_i),
        .hw_int_o(hw_int_o), .except_type_o(except_type_o), .cp0_en_o(cp0_en_o),
        .cur_inst_addr_o(cur_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .badvaddr_o(badvaddr_o), .mem_kill_o(mem_kill_o), .stall_o(stall_o),
        .flush_o(flush_o), .newpc_o(newpc_o), .newpc_valid_o(newpc_valid_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ds,
                                 input logic [7:0] exc, input logic [31:0] addr);
        m_valid_i        = valid;
        m_pc_i           = pc;
        m_in_delayslot_i = ds;
        m_exc_i          = exc;
        m_data_addr_i    = addr;
        #1;
    endtask

    // Full detect -> DRAIN -> COMMIT -> IDLE sequence with idle buses; garbage on the
    // memory-stage inputs during DRAIN must not disturb the captured context
    task automatic doExc(input string name, input logic [7:0] exc, input logic [31:0] pc, input logic ds,
                         input logic [31:0] addr, input logic [31:0] expType,
                         input logic [31:0] expBadv, input logic [31:0] expNewpc);
        applyStimulus(1'b1, pc, ds, exc, addr);
        checkOutput({name, " detect stall"}, {31'b0, stall_o}, 32'd1);
        checkOutput({name, " detect kill"}, {31'b0, mem_kill_o}, 32'd1);
        step();
        applyStimulus(1'b0, 32'hDEAD_BEEF, ~ds, 8'h01, 32'h1234_5678);
        checkOutput({name, " drain stall"}, {31'b0, stall_o}, 32'd1);
        checkOutput({name, " drain cp0_en"}, {31'b0, cp0_en_o}, 32'd0);
        step();
        checkOutput({name, " commit cp0_en"}, {31'b0, cp0_en_o}, 32'd1);
        checkOutput({name, " commit type"}, except_type_o, expType);
        checkOutput({name, " commit flush"}, {31'b0, flush_o}, 32'd1);
        checkOutput({name, " commit newpc_valid"}, {31'b0, newpc_valid_o}, 32'd1);
        checkOutput({name, " commit newpc"}, newpc_o, expNewpc);
        checkOutput({name, " commit stall"}, {31'b0, stall_o}, 32'd0);
        checkOutput({name, " commit pc"}, cur_inst_addr_o, pc);
        checkOutput({name, " commit delayslot"}, {31'b0, is_in_delayslot_o}, {31'b0, ds});
        checkOutput({name, " commit badvaddr"}, badvaddr_o, expBadv);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 32'h0);
        step();
        checkOutput({name, " idle type"}, except_type_o, 32'h0);
        checkOutput({name, " idle cp0_en"}, {31'b0, cp0_en_o}, 32'd0);
    endtask

    initial begin
        #2;
        checkOutput("reset stall", {31'b0, stall_o}, 32'd0);
        checkOutput("reset cp0_en", {31'b0, cp0_en_o}, 32'd0);
        checkOutput("reset type", except_type_o, 32'h0);
        checkOutput("reset hw_int", {26'b0, hw_int_o}, 32'h0);
        checkOutput("reset pc", cur_inst_addr_o, 32'h0);
        checkOutput("reset newpc", newpc_o, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Test 1: SYS, buses idle
        doExc("sys", 8'h08, 32'hBFC0_0100, 1'b0, 32'h0, TYPE_SYS, 32'h0, VEC);

        // Test 2: RI|OV|BP in delay slot -> RI wins
        doExc("ri", 8'h16, 32'h8000_0010, 1'b1, 32'h0, TYPE_RI, 32'h0, VEC);

        // ADEL-fetch reports the PC as bad address
        doExc("adelf", 8'h01, 32'hBFC0_0004, 1'b0, 32'h8000_0000, TYPE_ADEL, 32'hBFC0_0004, VEC);

        // Test 3: ADES with data bus busy for 5 cycles from detect
        dbus_busy_i = 1'b1;
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, 8'h40, 32'h8000_0003);
        checkOutput("ades detect kill", {31'b0, mem_kill_o}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 32'h0);
            if (k == 5) dbus_busy_i = 1'b0;
            #1;
            checkOutput($sformatf("ades drain%0d kill", k), {31'b0, mem_kill_o}, 32'd1);
            checkOutput($sformatf("ades drain%0d cp0_en", k), {31'b0, cp0_en_o}, 32'd0);
        end
        step();
        checkOutput("ades commit cp0_en", {31'b0, cp0_en_o}, 32'd1);
        checkOutput("ades commit type", except_type_o, TYPE_ADES);
        checkOutput("ades commit badvaddr", badvaddr_o, 32'h8000_0003);
        step();

        // Test 4: ext_int[1] through the synchroniser, IM3 enabled
        cp0_status_i = 32'h0000_0801;
        ext_int_i    = 6'b000010;
        applyStimulus(1'b1, 32'h8000_1000, 1'b0, 8'h00, 32'h0);
        checkOutput("int cycle0 stall", {31'b0, stall_o}, 32'd0);
        step();
        checkOutput("int cycle1 hw_int", {26'b0, hw_int_o}, 32'h0);
        checkOutput("int cycle1 stall", {31'b0, stall_o}, 32'd0);
        step();
        checkOutput("int cycle2 hw_int", {26'b0, hw_int_o}, 32'h2);
        checkOutput("int cycle2 stall", {31'b0, stall_o}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 32'h0);
        step();
        checkOutput("int commit type", except_type_o, TYPE_INT);
        checkOutput("int commit pc", cur_inst_addr_o, 32'h8000_1000);
        checkOutput("int commit newpc", newpc_o, VEC);
        step();
        cp0_status_i = 32'h0000_0803;
        applyStimulus(1'b1, 32'h8000_1004, 1'b0, 8'h00, 32'h0);
        checkOutput("int exl stall", {31'b0, stall_o}, 32'd0);
        step();
        checkOutput("int exl stall2", {31'b0, stall_o}, 32'd0);
        timer_int_i = 1'b1;
        #1;
        checkOutput("timer hw_int", {26'b0, hw_int_o}, 32'h22);
        timer_int_i = 1'b0;
        doExc("exl sys", 8'h08, 32'h8000_1008, 1'b0, 32'h0, TYPE_SYS, 32'h0, VEC);
        ext_int_i    = '0;
        cp0_status_i = '0;
        step();
        step();

        // Test 5: ERET redirects to EPC
        cp0_epc_i = 32'hBFC0_1234;
        doExc("eret", 8'h80, 32'h8000_0040, 1'b0, 32'h0, TYPE_ERET, 32'h0, 32'hBFC0_1234);

        // Test 6: reset in the middle of DRAIN
        dbus_busy_i = 1'b1;
        applyStimulus(1'b1, 32'h8000_0050, 1'b0, 8'h08, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 32'h0);
        checkOutput("rst pre stall", {31'b0, stall_o}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst async stall", {31'b0, stall_o}, 32'd0);
        checkOutput("rst async kill", {31'b0, mem_kill_o}, 32'd0);
        checkOutput("rst async pc", cur_inst_addr_o, 32'h0);
        step();
        dbus_busy_i = 1'b0;
        rst = 1'b0;
        step();
        checkOutput("rst after cp0_en", {31'b0, cp0_en_o}, 32'd0);
        checkOutput("rst after stall", {31'b0, stall_o}, 32'd0);
        doExc("post rst sys", 8'h08, 32'hBFC0_0200, 1'b0, 32'h0, TYPE_SYS, 32'h0, VEC);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
